rf_buffer_arbiter: RTL and testbench

Shares the single-port RF array buffer between the RISC-V core (single-beat accesses) and a DMA/RF-capture engine (multi-beat bursts). Sits directly in front of the buffer: it owns the buffer's read/write/address/data pins, arbitrates round-robin between core beats and burst starts, sequences bursts with auto-incrementing addresses, and routes the 1-cycle-latency read data back to the correct requester.

---
 rtl/rf_arb_pkg.sv | 20 ++
 rtl/rf_arb_burst_ctr.sv | 42 ++++
 rtl/rf_buffer_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rf_buffer_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared state/owner types for the RF buffer arbiter.
// Owner tags both the round-robin pointer and the read-response route.
package rf_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef enum logic {
      CORE = 1'b0,
      DMA  = 1'b1
   } owner_e;

   function automatic owner_e other_side(input owner_e o);
      return (o == CORE) ? DMA : CORE;
   endfunction

endpackage

// File: rtl/rf_arb_burst_ctr.sv
// rf_arb_burst_ctr: burst descriptor hold and beat counter.
// Address is base + beat, wrapping modulo 2^ADDR_WIDTH.
module rf_arb_burst_ctr
   import rf_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 10,
   parameter int BURST_LEN_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       load,
   input  logic [ADDR_WIDTH-1:0]      load_base,
   input  logic [BURST_LEN_WIDTH-1:0] load_len,
   input  logic                       advance,
   output logic [ADDR_WIDTH-1:0]      addr,
   output logic                       last_beat
);

   localparam logic [BURST_LEN_WIDTH-1:0] ONE = BURST_LEN_WIDTH'(1);

   logic [ADDR_WIDTH-1:0]      base_q;
   logic [BURST_LEN_WIDTH-1:0] len_q;
   logic [BURST_LEN_WIDTH-1:0] beat_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q <= '0;
         len_q  <= '0;
         beat_q <= '0;
      end else if (load) begin
         base_q <= load_base;
         len_q  <= load_len;
         beat_q <= '0;
      end else if (advance) begin
         beat_q <= beat_q + ONE;
      end
   end

   assign addr      = base_q + ADDR_WIDTH'(beat_q);
   assign last_beat = (beat_q == (len_q - ONE));

endmodule

// File: rtl/rf_buffer_arbiter.sv
// rf_buffer_arbiter: shares the single-port RF buffer between core and DMA.
// Optional core starvation guard: define RF_ARB_STARVE_GUARD_EN.
module rf_buffer_arbiter
   import rf_arb_pkg::*;
#(
   parameter int ADDR_WIDTH      = 10,
   parameter int DATA_WIDTH      = 32,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int MAX_WAIT        = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       core_req_valid,
   output logic                       core_req_ready,
   input  logic                       core_req_write,
   input  logic [ADDR_WIDTH-1:0]      core_req_addr,
   input  logic [DATA_WIDTH-1:0]      core_req_wdata,
   output logic                       core_rsp_valid,
   output logic [DATA_WIDTH-1:0]      core_rsp_rdata,
   input  logic                       dma_burst_valid,
   output logic                       dma_burst_ready,
   input  logic                       dma_burst_write,
   input  logic [ADDR_WIDTH-1:0]      dma_burst_base,
   input  logic [BURST_LEN_WIDTH-1:0] dma_burst_len,
   input  logic                       dma_wdata_valid,
   output logic                       dma_wdata_ready,
   input  logic [DATA_WIDTH-1:0]      dma_wdata,
   output logic                       dma_rsp_valid,
   output logic [DATA_WIDTH-1:0]      dma_rsp_rdata,
   output logic                       dma_burst_done,
   output logic                       buf_read,
   output logic                       buf_write,
   output logic [ADDR_WIDTH-1:0]      buf_addr,
   output logic [DATA_WIDTH-1:0]      buf_wdata,
   input  logic [DATA_WIDTH-1:0]      buf_rdata,
   output logic                       busy
);

   state_e state_q;
   state_e state_d;
   owner_e rr_q;
   owner_e rd_owner_q;

   logic active_q;
   logic rd_pend_q;
   logic done_q;
   logic bwrite_q;

   logic core_wins;
   logic core_grant;
   logic burst_acc;
   logic beat_issue;
   logic steal;
   logic len_zero;

   logic [ADDR_WIDTH-1:0] ctr_addr;
   logic                  last_beat;

   assign len_zero = (dma_burst_len == '0);

   rf_arb_burst_ctr #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .BURST_LEN_WIDTH (BURST_LEN_WIDTH)
   ) u_ctr (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (burst_acc),
      .load_base (dma_burst_base),
      .load_len  (dma_burst_len),
      .advance   (beat_issue),
      .addr      (ctr_addr),
      .last_beat (last_beat)
   );

`ifdef RF_ARB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

   logic [WAIT_W-1:0] wait_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_q <= '0;
      end else if (core_grant) begin
         wait_q <= '0;
      end else if (active_q && state_q == BURST && core_req_valid) begin
         wait_q <= wait_q + WAIT_ONE;
      end
   end

   assign steal = core_req_valid && (wait_q == WAIT_MAX);
`else
   assign steal = 1'b0;
`endif

   // active_q keeps every output quiet through the first cycle after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q   <= 1'b0;
         state_q    <= IDLE;
         rr_q       <= CORE;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= CORE;
         done_q     <= 1'b0;
         bwrite_q   <= 1'b0;
      end else begin
         active_q   <= 1'b1;
         state_q    <= state_d;
         rd_pend_q  <= buf_read;
         rd_owner_q <= core_grant ? CORE : DMA;
         done_q     <= (burst_acc && len_zero) ||
                       (beat_issue && last_beat && bwrite_q);
         if (core_grant) begin
            rr_q <= other_side(CORE);
         end else if (burst_acc) begin
            rr_q <= other_side(DMA);
         end
         if (burst_acc) begin
            bwrite_q <= dma_burst_write;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (burst_acc && !len_zero) state_d = BURST;
         end
         BURST: begin
            if (beat_issue && last_beat) begin
               state_d = bwrite_q ? IDLE : DRAIN;
            end
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      core_wins  = core_req_valid &&
                   (!dma_burst_valid || rr_q == CORE);
      core_grant = 1'b0;
      burst_acc  = 1'b0;
      beat_issue = 1'b0;
      if (active_q) begin
         unique case (state_q)
            IDLE: begin
               core_grant = core_wins;
               burst_acc  = dma_burst_valid && !core_wins;
            end
            BURST: begin
               core_grant = steal;
               beat_issue = !steal && (!bwrite_q || dma_wdata_valid);
            end
            default: begin
               core_grant = 1'b0;
            end
         endcase
      end
   end

   assign core_req_ready  = core_grant;
   assign dma_burst_ready = burst_acc;
   assign dma_wdata_ready = beat_issue && bwrite_q;

   assign buf_write = (core_grant && core_req_write) ||
                      (beat_issue && bwrite_q);
   assign buf_read  = (core_grant && !core_req_write) ||
                      (beat_issue && !bwrite_q);
   assign buf_addr  = core_grant ? core_req_addr :
                      beat_issue ? ctr_addr : '0;
   assign buf_wdata = (core_grant && core_req_write) ? core_req_wdata :
                      dma_wdata_ready ? dma_wdata : '0;

   assign core_rsp_valid = active_q && rd_pend_q && (rd_owner_q == CORE);
   assign dma_rsp_valid  = active_q && rd_pend_q && (rd_owner_q == DMA);
   assign core_rsp_rdata = core_rsp_valid ? buf_rdata : '0;
   assign dma_rsp_rdata  = dma_rsp_valid ? buf_rdata : '0;

   assign dma_burst_done = active_q && (done_q || state_q == DRAIN);
   assign busy           = active_q && (state_q != IDLE);

endmodule

// File: tb/tb_rf_buffer_arbiter.sv
// tb_rf_buffer_arbiter: directed bench with a 1-cycle-latency buffer model.
// Guard expectations follow RF_ARB_STARVE_GUARD_EN.
module tb_rf_buffer_arbiter;

   logic        clk;
   logic        reset_n;
   logic        core_req_valid;
   logic        core_req_ready;
   logic        core_req_write;
   logic [9:0]  core_req_addr;
   logic [31:0] core_req_wdata;
   logic        core_rsp_valid;
   logic [31:0] core_rsp_rdata;
   logic        dma_burst_valid;
   logic        dma_burst_ready;
   logic        dma_burst_write;
   logic [9:0]  dma_burst_base;
   logic [7:0]  dma_burst_len;
   logic        dma_wdata_valid;
   logic        dma_wdata_ready;
   logic [31:0] dma_wdata;
   logic        dma_rsp_valid;
   logic [31:0] dma_rsp_rdata;
   logic        dma_burst_done;
   logic        buf_read;
   logic        buf_write;
   logic [9:0]  buf_addr;
   logic [31:0] buf_wdata;
   logic [31:0] buf_rdata;
   logic        busy;

   logic [31:0] mem [0:1023];

   int n_tests = 0;
   int n_fail  = 0;

   rf_buffer_arbiter dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .core_req_valid  (core_req_valid),
      .core_req_ready  (core_req_ready),
      .core_req_write  (core_req_write),
      .core_req_addr   (core_req_addr),
      .core_req_wdata  (core_req_wdata),
      .core_rsp_valid  (core_rsp_valid),
      .core_rsp_rdata  (core_rsp_rdata),
      .dma_burst_valid (dma_burst_valid),
      .dma_burst_ready (dma_burst_ready),
      .dma_burst_write (dma_burst_write),
      .dma_burst_base  (dma_burst_base),
      .dma_burst_len   (dma_burst_len),
      .dma_wdata_valid (dma_wdata_valid),
      .dma_wdata_ready (dma_wdata_ready),
      .dma_wdata       (dma_wdata),
      .dma_rsp_valid   (dma_rsp_valid),
      .dma_rsp_rdata   (dma_rsp_rdata),
      .dma_burst_done  (dma_burst_done),
      .buf_read        (buf_read),
      .buf_write       (buf_write),
      .buf_addr        (buf_addr),
      .buf_wdata       (buf_wdata),
      .buf_rdata       (buf_rdata),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (buf_write) mem[buf_addr] <= buf_wdata;
      if (buf_read) buf_rdata <= mem[buf_addr];
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [9:0] ea [4];
   bit         wpat [4];
   int         wcnt;
   int         first_core;
   int         nrsp;
   int         ndone;
   int         nboth;
   int         nbusy;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      buf_rdata = '0;
      ea   = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      wpat = '{1'b1, 1'b0, 1'b1, 1'b1};

      reset_n         = 1'b0;
      core_req_valid  = 1'b1;
      core_req_write  = 1'b1;
      core_req_addr   = 10'h010;
      core_req_wdata  = 32'hDEAD_BEEF;
      dma_burst_valid = 1'b1;
      dma_burst_write = 1'b0;
      dma_burst_base  = '0;
      dma_burst_len   = 8'd0;
      dma_wdata_valid = 1'b0;
      dma_wdata       = '0;

      // reset and first cycle after release: everything quiet
      repeat (2) tick();
      check("rst_core_rdy", core_req_ready, 0);
      check("rst_dma_rdy", dma_burst_ready, 0);
      check("rst_buf_wr", buf_write, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      settle();
      check("rel_core_rdy", core_req_ready, 0);
      check("rel_buf_wr", buf_write, 0);

      // conflicts alternate starting with core
      tick(); settle();
      check("c1_core_rdy", core_req_ready, 1);
      check("c1_dma_rdy", dma_burst_ready, 0);
      check("c1_buf_wr", buf_write, 1);
      check("c1_addr", buf_addr, 32'h010);
      check("c1_wdata", buf_wdata, 32'hDEAD_BEEF);
      tick(); settle();
      check("c2_dma_rdy", dma_burst_ready, 1);
      check("c2_core_rdy", core_req_ready, 0);
      check("c2_no_acc", buf_write | buf_read, 0);
      tick(); core_req_write = 1'b0; settle();
      check("c3_core_rdy", core_req_ready, 1);
      check("c3_buf_rd", buf_read, 1);
      check("c3_zero_done", dma_burst_done, 1);
      tick(); settle();
      check("c4_dma_rdy", dma_burst_ready, 1);
      check("c4_core_rsp", core_rsp_valid, 1);
      check("c4_core_data", core_rsp_rdata, 32'hDEAD_BEEF);
      check("c4_dma_rsp", dma_rsp_valid, 0);
      check("c4_done", dma_burst_done, 0);
      tick();
      core_req_write = 1'b1;
      core_req_addr  = 10'h020;
      core_req_wdata = 32'h1111_2222;
      settle();
      check("c5_core_rdy", core_req_ready, 1);
      check("c5_done", dma_burst_done, 1);
      tick();
      core_req_valid  = 1'b0;
      dma_burst_valid = 1'b0;
      settle();
      check("idle_busy", busy, 0);

      // wrapping read burst
      tick();
      dma_burst_valid = 1'b1;
      dma_burst_write = 1'b0;
      dma_burst_base  = 10'h3FE;
      dma_burst_len   = 8'd4;
      settle();
      check("rb_acc", dma_burst_ready, 1);
      tick(); dma_burst_valid = 1'b0; settle();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            check("rb_rd", buf_read, 1);
            check("rb_addr", buf_addr, ea[i]);
         end
         if (i >= 1 && i <= 4) begin
            check("rb_rsp", dma_rsp_valid, 1);
            check("rb_data", dma_rsp_rdata, 32'hC0DE_0000 | 32'(ea[i-1]));
         end
         check("rb_done", dma_burst_done, 32'(i == 4));
         check("rb_busy", busy, 32'(i < 5));
         tick(); settle();
      end

      // gapped write burst
      dma_burst_valid = 1'b1;
      dma_burst_write = 1'b1;
      dma_burst_base  = 10'h100;
      dma_burst_len   = 8'd3;
      settle();
      check("wb_acc", dma_burst_ready, 1);
      tick();
      dma_burst_valid = 1'b0;
      wcnt = 0;
      for (int i = 0; i < 4; i++) begin
         dma_wdata_valid = wpat[i];
         dma_wdata       = 32'hA0 + 32'(i);
         settle();
         check("wb_rdy", dma_wdata_ready, 32'(wpat[i]));
         check("wb_early_done", dma_burst_done, 0);
         check("wb_busy", busy, 1);
         if (buf_write) begin
            check("wb_addr", buf_addr, 32'h100 + 32'(wcnt));
            wcnt++;
         end
         tick();
      end
      dma_wdata_valid = 1'b0;
      settle();
      check("wb_cnt", wcnt, 3);
      check("wb_done", dma_burst_done, 1);
      check("wb_idle", busy, 0);
      tick(); settle();
      check("wb_done_once", dma_burst_done, 0);

      // long read burst with core requesting throughout
      dma_burst_valid = 1'b1;
      dma_burst_write = 1'b0;
      dma_burst_base  = 10'h000;
      dma_burst_len   = 8'd64;
      settle();
      check("gd_acc", dma_burst_ready, 1);
      tick();
      dma_burst_valid = 1'b0;
      core_req_valid  = 1'b1;
      core_req_write  = 1'b0;
      core_req_addr   = 10'h010;
      first_core = 0;
      nrsp  = 0;
      ndone = 0;
      nboth = 0;
      for (int c = 1; c <= 80; c++) begin
         settle();
         if (core_req_ready && first_core == 0) first_core = c;
         if (dma_rsp_valid) nrsp++;
         if (dma_burst_done) ndone++;
         if (buf_read && buf_write) nboth++;
         tick();
      end
      core_req_valid = 1'b0;
      check("gd_beats", nrsp, 64);
      check("gd_done", ndone, 1);
      check("gd_rdwr", nboth, 0);
`ifdef RF_ARB_STARVE_GUARD_EN
      check("gd_first_core", first_core, 17);
`else
      check("gd_first_core", first_core, 66);
`endif

      // reset in the middle of a read burst
      dma_burst_valid = 1'b1;
      dma_burst_base  = 10'h200;
      dma_burst_len   = 8'd10;
      settle();
      check("rs_acc", dma_burst_ready, 1);
      tick();
      dma_burst_valid = 1'b0;
      repeat (4) tick();
      settle();
      check("rs_pre_busy", busy, 1);
      check("rs_pre_rd", buf_read, 1);
      reset_n = 1'b0;
      settle();
      check("rs_rd", buf_read, 0);
      check("rs_busy", busy, 0);
      check("rs_rsp", dma_rsp_valid, 0);
      check("rs_done", dma_burst_done, 0);
      check("rs_addr", buf_addr, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      ndone = 0;
      nbusy = 0;
      for (int c = 0; c < 14; c++) begin
         tick(); settle();
         if (dma_burst_done) ndone++;
         if (busy) nbusy++;
      end
      check("rs_no_done", ndone, 0);
      check("rs_idle", nbusy, 0);
      core_req_valid = 1'b1;
      core_req_write = 1'b0;
      core_req_addr  = 10'h010;
      settle();
      check("rs_core_rdy", core_req_ready, 1);
      tick();
      core_req_valid = 1'b0;
      settle();
      check("rs_core_rsp", core_rsp_valid, 1);
      check("rs_core_data", core_rsp_rdata, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
